// File: rtl/sgpr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// sgpr_wr_arbiter
//
// Merges scalar-ALU writebacks and LSU scalar-load writebacks onto the single
// SGPR write port. SALU writes are one-cycle pulses, so they are captured in
// a small FIFO and drained under round-robin arbitration against the LSU,
// whose request is a level held until lsu_grant.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   salu_req/wr_en/addr/data/wfid SALU write pulse and payload
//   lsu_req/wr_en/addr/data/wfid  LSU write request (level) and payload
//   lsu_grant                     LSU request accepted this cycle (comb)
//   salu_hold                     SALU buffer cannot absorb two more writes
//   sgpr_wr_en/addr/data          registered SGPR write port
//   salu_done, salu_done_wfid     SALU write retired (one-cycle pulse)
//   lsu_done, lsu_done_wfid       LSU write retired (one-cycle pulse)
//
// Optional feature (macro SGPR_ARB_PERF_CNT_EN): adds 32-bit wrapping
// counters perf_salu_wr_cnt, perf_lsu_wr_cnt and perf_contend_cnt.
// ---------------------------------------------------------------------------
module sgpr_wr_arbiter #(
    parameter int SALU_BUF_DEPTH = 2,
    parameter int SALU_PTR_W     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        salu_req,
    input  logic [1:0]  salu_wr_en,
    input  logic [8:0]  salu_addr,
    input  logic [63:0] salu_data,
    input  logic [5:0]  salu_wfid,
    input  logic        lsu_req,
    input  logic [1:0]  lsu_wr_en,
    input  logic [8:0]  lsu_addr,
    input  logic [63:0] lsu_data,
    input  logic [5:0]  lsu_wfid,
    output logic        lsu_grant,
    output logic        salu_hold,
    output logic [1:0]  sgpr_wr_en,
    output logic [8:0]  sgpr_wr_addr,
    output logic [63:0] sgpr_wr_data,
    output logic        salu_done,
    output logic [5:0]  salu_done_wfid,
    output logic        lsu_done,
    output logic [5:0]  lsu_done_wfid
`ifdef SGPR_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_salu_wr_cnt,
    output logic [31:0] perf_lsu_wr_cnt,
    output logic [31:0] perf_contend_cnt
`endif
);

    localparam int CNT_W = SALU_PTR_W + 1;

    typedef enum logic {
        RR_LSU  = 1'b0,
        RR_SALU = 1'b1
    } rr_e;

    // SALU FIFO storage
    logic [1:0]  buf_en   [SALU_BUF_DEPTH];
    logic [8:0]  buf_addr [SALU_BUF_DEPTH];
    logic [63:0] buf_data [SALU_BUF_DEPTH];
    logic [5:0]  buf_wfid [SALU_BUF_DEPTH];

    logic [SALU_PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count, count_next;
    rr_e                   rr_q, rr_next;

    logic s_cand, l_cand, contend;
    logic grant_s, grant_l;
    logic push_req, push, full, overflow;

    // NOTE: always_comb assigns every output a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        s_cand     = 1'b0;
        l_cand     = 1'b0;
        contend    = 1'b0;
        grant_s    = 1'b0;
        grant_l    = 1'b0;
        push_req   = 1'b0;
        push       = 1'b0;
        full       = 1'b0;
        overflow   = 1'b0;
        rr_next    = rr_q;

        s_cand   = (count != '0);
        l_cand   = lsu_req && (lsu_wr_en != 2'b00);
        contend  = s_cand && l_cand;
        grant_s  = s_cand && (!l_cand || (rr_q == RR_SALU));
        grant_l  = l_cand && !grant_s;

        // A full FIFO can still accept a write in a cycle that pops the head,
        // since the freed slot is the one being written.
        push_req = salu_req && (salu_wr_en != 2'b00);
        full     = (count == CNT_W'(SALU_BUF_DEPTH));
        push     = push_req && (!full || grant_s);
        overflow = push_req && full && !grant_s;

        // The pointer only moves on contested cycles, to the side that lost.
        if (contend)
            rr_next = (rr_q == RR_SALU) ? RR_LSU : RR_SALU;

        count_next = count + CNT_W'(push) - CNT_W'(grant_s);
    end

    assign lsu_grant = grant_l;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= RR_SALU;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            salu_hold <= 1'b0;
        end else begin
            rr_q      <= rr_next;
            count     <= count_next;
            salu_hold <= (count_next >= CNT_W'(SALU_BUF_DEPTH - 1));
            if (push)
                wr_ptr <= wr_ptr + SALU_PTR_W'(1);
            if (grant_s)
                rd_ptr <= rd_ptr + SALU_PTR_W'(1);
        end
    end

    // NOTE: the payload array has no reset; count and pointers gate every
    // read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_en[wr_ptr]   <= salu_wr_en;
            buf_addr[wr_ptr] <= salu_addr;
            buf_data[wr_ptr] <= salu_data;
            buf_wfid[wr_ptr] <= salu_wfid;
        end
    end

    // Registered SGPR port; addr/data hold their last value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgpr_wr_en     <= 2'b00;
            sgpr_wr_addr   <= '0;
            sgpr_wr_data   <= '0;
            salu_done      <= 1'b0;
            salu_done_wfid <= '0;
            lsu_done       <= 1'b0;
            lsu_done_wfid  <= '0;
        end else begin
            sgpr_wr_en <= 2'b00;
            salu_done  <= 1'b0;
            lsu_done   <= 1'b0;
            if (grant_s) begin
                sgpr_wr_en     <= buf_en[rd_ptr];
                sgpr_wr_addr   <= buf_addr[rd_ptr];
                sgpr_wr_data   <= buf_data[rd_ptr];
                salu_done      <= 1'b1;
                salu_done_wfid <= buf_wfid[rd_ptr];
            end else if (grant_l) begin
                sgpr_wr_en    <= lsu_wr_en;
                sgpr_wr_addr  <= lsu_addr;
                sgpr_wr_data  <= lsu_data;
                lsu_done      <= 1'b1;
                lsu_done_wfid <= lsu_wfid;
            end
        end
    end

`ifdef SGPR_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_salu_wr_cnt <= '0;
            perf_lsu_wr_cnt  <= '0;
            perf_contend_cnt <= '0;
        end else begin
            if (grant_s)
                perf_salu_wr_cnt <= perf_salu_wr_cnt + 32'd1;
            if (grant_l)
                perf_lsu_wr_cnt <= perf_lsu_wr_cnt + 32'd1;
            if (contend)
                perf_contend_cnt <= perf_contend_cnt + 32'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // The SALU must honour salu_hold; a push into a full, non-draining
    // buffer loses a write.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!overflow)
            else $error("sgpr_wr_arbiter: SALU write dropped, buffer full");
    end
`endif

endmodule

// File: tb/tb_sgpr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sgpr_wr_arbiter
//
// Directed, table-driven bench for sgpr_wr_arbiter. Each table row is one
// clock cycle: inputs are driven after the falling edge, lsu_grant is checked
// before the rising edge, and the registered port/done/hold outputs produced
// by that cycle's decision are checked just after the rising edge. A
// hand-written sequence then covers asynchronous reset with buffered writes.
// ---------------------------------------------------------------------------
module tb_sgpr_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        salu_req;
    logic [1:0]  salu_wr_en;
    logic [8:0]  salu_addr;
    logic [63:0] salu_data;
    logic [5:0]  salu_wfid;
    logic        lsu_req;
    logic [1:0]  lsu_wr_en;
    logic [8:0]  lsu_addr;
    logic [63:0] lsu_data;
    logic [5:0]  lsu_wfid;
    logic        lsu_grant;
    logic        salu_hold;
    logic [1:0]  sgpr_wr_en;
    logic [8:0]  sgpr_wr_addr;
    logic [63:0] sgpr_wr_data;
    logic        salu_done;
    logic [5:0]  salu_done_wfid;
    logic        lsu_done;
    logic [5:0]  lsu_done_wfid;
`ifdef SGPR_ARB_PERF_CNT_EN
    logic [31:0] perf_salu_wr_cnt;
    logic [31:0] perf_lsu_wr_cnt;
    logic [31:0] perf_contend_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sgpr_wr_arbiter #(.SALU_BUF_DEPTH(2), .SALU_PTR_W(1)) dut (
        .clk(clk), .rst(rst),
        .salu_req(salu_req), .salu_wr_en(salu_wr_en), .salu_addr(salu_addr),
        .salu_data(salu_data), .salu_wfid(salu_wfid),
        .lsu_req(lsu_req), .lsu_wr_en(lsu_wr_en), .lsu_addr(lsu_addr),
        .lsu_data(lsu_data), .lsu_wfid(lsu_wfid),
        .lsu_grant(lsu_grant), .salu_hold(salu_hold),
        .sgpr_wr_en(sgpr_wr_en), .sgpr_wr_addr(sgpr_wr_addr), .sgpr_wr_data(sgpr_wr_data),
        .salu_done(salu_done), .salu_done_wfid(salu_done_wfid),
        .lsu_done(lsu_done), .lsu_done_wfid(lsu_done_wfid)
`ifdef SGPR_ARB_PERF_CNT_EN
        ,
        .perf_salu_wr_cnt(perf_salu_wr_cnt), .perf_lsu_wr_cnt(perf_lsu_wr_cnt),
        .perf_contend_cnt(perf_contend_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s_req;
        logic [1:0]  s_en;
        logic [8:0]  s_addr;
        logic [63:0] s_data;
        logic [5:0]  s_wfid;
        logic        l_req;
        logic [1:0]  l_en;
        logic [8:0]  l_addr;
        logic [63:0] l_data;
        logic [5:0]  l_wfid;
        logic        e_grant;
        logic [1:0]  e_en;
        logic [8:0]  e_addr;
        logic [63:0] e_data;
        logic        e_sdone;
        logic [5:0]  e_swfid;
        logic        e_ldone;
        logic [5:0]  e_lwfid;
        logic        e_hold;
    } vec_t;

    function automatic vec_t mk(
        input logic s_req, input logic [1:0] s_en, input logic [8:0] s_addr,
        input logic [63:0] s_data, input logic [5:0] s_wfid,
        input logic l_req, input logic [1:0] l_en, input logic [8:0] l_addr,
        input logic [63:0] l_data, input logic [5:0] l_wfid,
        input logic e_grant, input logic [1:0] e_en, input logic [8:0] e_addr,
        input logic [63:0] e_data, input logic e_sdone, input logic [5:0] e_swfid,
        input logic e_ldone, input logic [5:0] e_lwfid, input logic e_hold);
        vec_t v;
        v.s_req = s_req; v.s_en = s_en; v.s_addr = s_addr; v.s_data = s_data; v.s_wfid = s_wfid;
        v.l_req = l_req; v.l_en = l_en; v.l_addr = l_addr; v.l_data = l_data; v.l_wfid = l_wfid;
        v.e_grant = e_grant; v.e_en = e_en; v.e_addr = e_addr; v.e_data = e_data;
        v.e_sdone = e_sdone; v.e_swfid = e_swfid; v.e_ldone = e_ldone; v.e_lwfid = e_lwfid;
        v.e_hold = e_hold;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        salu_req = 1'b0; salu_wr_en = 2'b00; salu_addr = '0; salu_data = '0; salu_wfid = '0;
        lsu_req  = 1'b0; lsu_wr_en  = 2'b00; lsu_addr  = '0; lsu_data  = '0; lsu_wfid  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " lsu_grant"}, 64'(lsu_grant), 64'd0);
        check({tag, " salu_hold"}, 64'(salu_hold), 64'd0);
        check({tag, " sgpr_wr_en"}, 64'(sgpr_wr_en), 64'd0);
        check({tag, " sgpr_wr_addr"}, 64'(sgpr_wr_addr), 64'd0);
        check({tag, " sgpr_wr_data"}, sgpr_wr_data, 64'd0);
        check({tag, " salu_done"}, 64'(salu_done), 64'd0);
        check({tag, " salu_done_wfid"}, 64'(salu_done_wfid), 64'd0);
        check({tag, " lsu_done"}, 64'(lsu_done), 64'd0);
        check({tag, " lsu_done_wfid"}, 64'(lsu_done_wfid), 64'd0);
`ifdef SGPR_ARB_PERF_CNT_EN
        check({tag, " perf_salu_wr_cnt"}, 64'(perf_salu_wr_cnt), 64'd0);
        check({tag, " perf_lsu_wr_cnt"}, 64'(perf_lsu_wr_cnt), 64'd0);
        check({tag, " perf_contend_cnt"}, 64'(perf_contend_cnt), 64'd0);
`endif
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        salu_req = v.s_req; salu_wr_en = v.s_en; salu_addr = v.s_addr;
        salu_data = v.s_data; salu_wfid = v.s_wfid;
        lsu_req = v.l_req; lsu_wr_en = v.l_en; lsu_addr = v.l_addr;
        lsu_data = v.l_data; lsu_wfid = v.l_wfid;
        #1;
        check({tag, " lsu_grant"}, 64'(lsu_grant), 64'(v.e_grant));
        @(posedge clk);
        #1;
        check({tag, " sgpr_wr_en"}, 64'(sgpr_wr_en), 64'(v.e_en));
        check({tag, " salu_done"}, 64'(salu_done), 64'(v.e_sdone));
        check({tag, " lsu_done"}, 64'(lsu_done), 64'(v.e_ldone));
        check({tag, " salu_hold"}, 64'(salu_hold), 64'(v.e_hold));
        if (v.e_en != 2'b00) begin
            check({tag, " sgpr_wr_addr"}, 64'(sgpr_wr_addr), 64'(v.e_addr));
            check({tag, " sgpr_wr_data"}, sgpr_wr_data, v.e_data);
        end
        if (v.e_sdone)
            check({tag, " salu_done_wfid"}, 64'(salu_done_wfid), 64'(v.e_swfid));
        if (v.e_ldone)
            check({tag, " lsu_done_wfid"}, 64'(lsu_done_wfid), 64'(v.e_lwfid));
    endtask

    vec_t vecs[29];

    initial begin
        // Payload shorthands
        logic [63:0] d0, da1, da2, db1, db2, db3, dc1, dc2, dd1, dd2, dd3, dd4, de1, de2, de3, dl;
        d0  = 64'h0;
        dl  = 64'h1111_2222_3333_4444;
        da1 = 64'hA0A0_0000_0000_0001; da2 = 64'hA0A0_0000_0000_0002;
        db1 = 64'hB0B0_0000_0000_0001; db2 = 64'hB0B0_0000_0000_0002; db3 = 64'hB0B0_0000_0000_0003;
        dc1 = 64'hC0C0_0000_0000_0001; dc2 = 64'hC0C0_0000_0000_0002;
        dd1 = 64'hD0D0_0000_0000_0001; dd2 = 64'hD0D0_0000_0000_0002;
        dd3 = 64'hD0D0_0000_0000_0003; dd4 = 64'hD0D0_0000_0000_0004;
        de1 = 64'hE0E0_0000_0000_0001; de2 = 64'hE0E0_0000_0000_0002; de3 = 64'hE0E0_0000_0000_0003;

        //              salu: req en     addr    data                    wfid  lsu: req en     addr    data wfid  exp: gnt en     addr    data                    sd swfid ld lwfid hold
        // single SALU write, visible two cycles after the pulse
        vecs[0]  = mk(1, 2'b11, 9'h010, 64'hDEADBEEF_CAFEF00D, 6'd5,  0, 2'b00, 9'h000, d0,  6'd0,  0, 2'b00, 9'h000, d0,                     0, 6'd0,  0, 6'd0,  1);
        vecs[1]  = mk(0, 2'b00, 9'h000, d0,                    6'd0,  0, 2'b00, 9'h000, d0,  6'd0,  0, 2'b11, 9'h010, 64'hDEADBEEF_CAFEF00D, 1, 6'd5,  0, 6'd0,  0);
        vecs[2]  = mk(0, 2'b00, 9'h000, d0,                    6'd0,  0, 2'b00, 9'h000, d0,  6'd0,  0, 2'b00, 9'h000, d0,                     0, 6'd0,  0, 6'd0,  0);
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        // LSU alone, one write then drop
        vecs[5]  = mk(0, 2'b00, 9'h000, d0,                    6'd0,  1, 2'b01, 9'h020, dl,  6'd9,  1, 2'b01, 9'h020, dl,                     0, 6'd0,  1, 6'd9,  0);
        vecs[6]  = vecs[2];
        vecs[7]  = vecs[2];
        // contention: SALU A buffered, LSU L1..L3, SALU B pushed mid-stream
        vecs[8]  = mk(1, 2'b11, 9'h030, da1, 6'd1,  0, 2'b00, 9'h000, d0,  6'd0,   0, 2'b00, 9'h000, d0,  0, 6'd0,  0, 6'd0,  1);
        vecs[9]  = mk(0, 2'b00, 9'h000, d0,  6'd0,  1, 2'b11, 9'h040, db1, 6'd2,   0, 2'b11, 9'h030, da1, 1, 6'd1,  0, 6'd0,  0);
        vecs[10] = mk(1, 2'b10, 9'h031, da2, 6'd4,  1, 2'b11, 9'h040, db1, 6'd2,   1, 2'b11, 9'h040, db1, 0, 6'd0,  1, 6'd2,  1);
        vecs[11] = mk(0, 2'b00, 9'h000, d0,  6'd0,  1, 2'b10, 9'h041, db2, 6'd3,   1, 2'b10, 9'h041, db2, 0, 6'd0,  1, 6'd3,  1);
        vecs[12] = mk(0, 2'b00, 9'h000, d0,  6'd0,  1, 2'b01, 9'h042, db3, 6'd6,   0, 2'b10, 9'h031, da2, 1, 6'd4,  0, 6'd0,  0);
        vecs[13] = mk(0, 2'b00, 9'h000, d0,  6'd0,  1, 2'b01, 9'h042, db3, 6'd6,   1, 2'b01, 9'h042, db3, 0, 6'd0,  1, 6'd6,  0);
        vecs[14] = vecs[2];
        // back-to-back SALU pushes vs continuous LSU (pointer starts at LSU)
        vecs[15] = mk(1, 2'b11, 9'h050, dc1, 6'd10, 1, 2'b11, 9'h060, dd1, 6'd20,  1, 2'b11, 9'h060, dd1, 0, 6'd0,  1, 6'd20, 1);
        vecs[16] = mk(1, 2'b01, 9'h051, dc2, 6'd11, 1, 2'b11, 9'h061, dd2, 6'd21,  1, 2'b11, 9'h061, dd2, 0, 6'd0,  1, 6'd21, 1);
        vecs[17] = mk(0, 2'b00, 9'h000, d0,  6'd0,  1, 2'b11, 9'h062, dd3, 6'd22,  0, 2'b11, 9'h050, dc1, 1, 6'd10, 0, 6'd0,  1);
        vecs[18] = mk(0, 2'b00, 9'h000, d0,  6'd0,  1, 2'b11, 9'h062, dd3, 6'd22,  1, 2'b11, 9'h062, dd3, 0, 6'd0,  1, 6'd22, 1);
        vecs[19] = mk(0, 2'b00, 9'h000, d0,  6'd0,  1, 2'b11, 9'h063, dd4, 6'd23,  0, 2'b01, 9'h051, dc2, 1, 6'd11, 0, 6'd0,  0);
        vecs[20] = mk(0, 2'b00, 9'h000, d0,  6'd0,  1, 2'b11, 9'h063, dd4, 6'd23,  1, 2'b11, 9'h063, dd4, 0, 6'd0,  1, 6'd23, 0);
        vecs[21] = vecs[2];
        // SALU stream, push and pop in the same cycle keep count at 1
        vecs[22] = mk(1, 2'b11, 9'h070, de1, 6'd30, 0, 2'b00, 9'h000, d0,  6'd0,   0, 2'b00, 9'h000, d0,  0, 6'd0,  0, 6'd0,  1);
        vecs[23] = mk(1, 2'b11, 9'h071, de2, 6'd31, 0, 2'b00, 9'h000, d0,  6'd0,   0, 2'b11, 9'h070, de1, 1, 6'd30, 0, 6'd0,  1);
        vecs[24] = mk(1, 2'b11, 9'h072, de3, 6'd32, 0, 2'b00, 9'h000, d0,  6'd0,   0, 2'b11, 9'h071, de2, 1, 6'd31, 0, 6'd0,  1);
        vecs[25] = mk(0, 2'b00, 9'h000, d0,  6'd0,  0, 2'b00, 9'h000, d0,  6'd0,   0, 2'b11, 9'h072, de3, 1, 6'd32, 0, 6'd0,  0);
        vecs[26] = vecs[2];
        // zero-enable requests are ignored on both sides
        vecs[27] = mk(1, 2'b00, 9'h0AA, 64'hF1, 6'd7, 1, 2'b00, 9'h0BB, 64'hF2, 6'd8, 0, 2'b00, 9'h000, d0, 0, 6'd0, 0, 6'd0, 0);
        vecs[28] = vecs[2];

        // reset state
        rst = 1'b1;
        drive_idle();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            apply(vecs[i], $sformatf("row%0d", i));

        // Async reset with two buffered SALU entries and an LSU write on the port
        @(negedge clk);
        salu_req = 1'b1; salu_wr_en = 2'b11; salu_addr = 9'h080; salu_data = 64'h7777_0000_0000_0001; salu_wfid = 6'd40;
        lsu_req  = 1'b1; lsu_wr_en  = 2'b11; lsu_addr  = 9'h090; lsu_data  = 64'h8888_0000_0000_0001; lsu_wfid  = 6'd50;
        #1;
        check("rst_seq c0 lsu_grant", 64'(lsu_grant), 64'd1);
        @(posedge clk);
        #1;
        check("rst_seq c0 lsu_done", 64'(lsu_done), 64'd1);
        @(negedge clk);
        salu_addr = 9'h081; salu_data = 64'h7777_0000_0000_0002; salu_wfid = 6'd41;
        lsu_wr_en = 2'b01; lsu_addr = 9'h091; lsu_data = 64'h8888_0000_0000_0002; lsu_wfid = 6'd51;
        #1;
        check("rst_seq c1 lsu_grant", 64'(lsu_grant), 64'd1);
        @(posedge clk);
        #1;
        check("rst_seq c1 sgpr_wr_en", 64'(sgpr_wr_en), 64'h1);
        check("rst_seq c1 salu_hold", 64'(salu_hold), 64'd1);
`ifdef SGPR_ARB_PERF_CNT_EN
        check("perf_salu_wr_cnt", 64'(perf_salu_wr_cnt), 64'd8);
        check("perf_lsu_wr_cnt", 64'(perf_lsu_wr_cnt), 64'd10);
        check("perf_contend_cnt", 64'(perf_contend_cnt), 64'd8);
`endif
        #1;
        drive_idle();
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++)
            apply(vecs[2], $sformatf("post_rst%0d", k));

        // Pointer back at SALU after reset: buffered SALU wins the contested cycle
        apply(mk(1, 2'b11, 9'h0A0, 64'h9999_0000_0000_0001, 6'd60, 0, 2'b00, 9'h000, d0, 6'd0,
                 0, 2'b00, 9'h000, d0, 0, 6'd0, 0, 6'd0, 1), "rr_rst0");
        apply(mk(0, 2'b00, 9'h000, d0, 6'd0, 1, 2'b10, 9'h0B0, 64'h9999_0000_0000_0002, 6'd61,
                 0, 2'b11, 9'h0A0, 64'h9999_0000_0000_0001, 1, 6'd60, 0, 6'd0, 0), "rr_rst1");
        apply(mk(0, 2'b00, 9'h000, d0, 6'd0, 1, 2'b10, 9'h0B0, 64'h9999_0000_0000_0002, 6'd61,
                 1, 2'b10, 9'h0B0, 64'h9999_0000_0000_0002, 0, 6'd0, 1, 6'd61, 0), "rr_rst2");
        apply(vecs[2], "rr_rst3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sgpr_wr_arbiter.md
Name: sgpr_wr_arbiter

Overview:
- Sits directly downstream of the scalar ALU writeback stage, in front of the single SGPR write port.
- Merges SALU writebacks with LSU scalar-load writebacks onto that one port.
- A SALU write is valid for exactly one cycle, so SALU writes are captured into a small FIFO and drained under round-robin arbitration against the LSU.
- Reports per-source write completion (wfid) to the issue/scoreboard logic and drives a hold line the SALU uses to stop accepting instructions.

Parameters:
- SALU_BUF_DEPTH, 2, SALU write FIFO entries; power of two, minimum 2.
- SALU_PTR_W, 1, log2(SALU_BUF_DEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- salu_req  in  1  SALU write pulse (the SALU's double-flopped SGPR request); one cycle per write
- salu_wr_en  in  2  SALU dword enables; [0] = low dword, [1] = high dword
- salu_addr  in  9  SALU destination SGPR address
- salu_data  in  64  SALU write data
- salu_wfid  in  6  SALU wavefront id
- lsu_req  in  1  LSU write request; level, held until granted
- lsu_wr_en  in  2  LSU dword enables
- lsu_addr  in  9  LSU destination SGPR address
- lsu_data  in  64  LSU write data
- lsu_wfid  in  6  LSU wavefront id
- lsu_grant  out  1  LSU request accepted this cycle (combinational)
- salu_hold  out  1  SALU buffer not able to absorb two more writes
- sgpr_wr_en  out  2  SGPR port dword enables (registered)
- sgpr_wr_addr  out  9  SGPR port address (registered)
- sgpr_wr_data  out  64  SGPR port data (registered)
- salu_done  out  1  SALU write retired to SGPR (registered)
- salu_done_wfid  out  6  wfid of the retired SALU write
- lsu_done  out  1  LSU write retired to SGPR (registered)
- lsu_done_wfid  out  6  wfid of the retired LSU write

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - All outputs are 0.
  - FIFO count, read pointer and write pointer are 0.
  - The round-robin pointer is set to SALU.
- SALU capture:
  - When salu_req=1 and salu_wr_en!=0, {wr_en, addr, data, wfid} is pushed into the FIFO in the same edge.
  - salu_req with wr_en==0 is ignored.
  - A push when the FIFO is full is a protocol error. The entry is dropped, the count saturates, and a simulation-only assertion fires.
- Arbitration uses combinational candidates each cycle:
  - S = FIFO non-empty.
  - L = lsu_req with lsu_wr_en!=0.
  - Only S: grant SALU head.
  - Only L: grant LSU.
  - Both: grant the side named by the RR pointer, then move the pointer to the other side.
  - The pointer only updates on contested cycles.
- Grant effects:
  - The granted write is registered onto the sgpr_wr_* outputs next cycle (1-cycle latency).
  - In that same cycle the matching *_done/*_done_wfid pulses for one cycle.
  - A SALU grant pops the FIFO.
  - lsu_grant is asserted combinationally in the granting cycle. The LSU drops or advances its request on the following edge.
  - With no grant, sgpr_wr_en=0 and both done signals are 0; addr/data hold their last values.
- Push and pop in the same cycle leave the count unchanged. This covers the empty case: an arriving SALU write is not bypassed and is first granted the cycle after the push.
- Minimum SALU latency: salu_req at cycle N → sgpr_wr_en at N+2 when the LSU is idle.
- Pointers wrap modulo SALU_BUF_DEPTH.
- salu_hold = (count_next >= SALU_BUF_DEPTH-1), registered.
  - The SALU has at most one further write in flight after seeing hold.
  - One free entry therefore guarantees no overflow.
- LSU starvation is bounded: with both sources continuously pending, grants alternate S, L, S, L.
- Reset mid-operation: buffered SALU writes are discarded, and any in-flight sgpr_wr_en is cleared asynchronously.

Optional Feature:
- Macro SGPR_ARB_PERF_CNT_EN.
- When defined, adds outputs:
  - perf_salu_wr_cnt (32, out): count of SALU writes retired.
  - perf_lsu_wr_cnt (32, out): count of LSU writes retired.
  - perf_contend_cnt (32, out): count of cycles in which both S and L were pending.
- All three counters reset to 0, wrap at 2^32, and increment on the same edge as the related grant or condition.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Single SALU write: salu_req=1, wr_en=2'b11, addr=9'h010, data=64'hDEADBEEF_CAFEF00D, wfid=5 at cycle 0 → sgpr_wr_en=2'b11 with that addr/data at cycle 2, salu_done=1, salu_done_wfid=5; nothing else for 4 cycles.
- LSU alone: lsu_req held with wr_en=2'b01, addr=9'h020, wfid=9 → lsu_grant same cycle, sgpr_wr_en=2'b01 next cycle with lsu_done_wfid=9; when the request drops, no further writes.
- Contention: FIFO holds 1 SALU entry while lsu_req is held for 3 writes, RR pointer = SALU → port order SALU, LSU, LSU; a second SALU push mid-stream is interleaved as S, L alternation.
- Back-to-back SALU pushes with the LSU continuously winning the alternate slot → salu_hold=1 once count reaches 1 (depth 2); no assertion fires; all SALU writes retire in push order.
- Zero-enable filtering: salu_req=1 with wr_en=0, and lsu_req=1 with wr_en=0 → no push, no grant, no done pulses.
- Async reset asserted with 2 buffered entries and a write on the port → all outputs 0 immediately; after deassertion no stale writes appear; with SGPR_ARB_PERF_CNT_EN, counters read 0.
